spill_reg: RTL and testbench



---
 rtl/spill_reg_pkg.sv | 24 ++
 rtl/spill_reg_dfflr.sv | 20 ++
 rtl/spill_reg.sv | 130 +++++++++++++
 tb/tb_spill_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spill_reg_pkg.sv
// Shared types for the spill register: occupancy states and the decode
// from the two slot full flags.
package spill_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_e;

    // B is only ever filled while A is full, so {B=1, A=0} cannot occur.
    function automatic state_e decode_state(input logic a_full, input logic b_full);
        state_e st;
        if (!a_full && !b_full) begin
            st = ST_EMPTY;
        end else if (a_full && !b_full) begin
            st = ST_ONE;
        end else begin
            st = ST_FULL;
        end
        return st;
    endfunction

endpackage

// File: rtl/spill_reg_dfflr.sv
// Load-enabled register with asynchronous active-low reset to zero.
module dfflr #(
    parameter int unsigned DATA_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/spill_reg.sv
// Two-entry skid buffer between valid/ready producer and consumer; every
// output is driven straight from a flop. BYPASS=1 reduces it to wires.
module spill_reg
    import spill_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          BYPASS     = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [1:0]            count_o
);

    generate
        if (BYPASS) begin : g_bypass
            assign valid_o = valid_i;
            assign dat_o   = dat_i;
            assign ready_o = ready_i;
            assign count_o = '0;
        end else begin : g_reg
            logic                  a_full_q;
            logic                  a_full_d;
            logic                  b_full_q;
            logic                  b_full_d;
            logic                  a_load;
            logic                  b_load;
            logic                  a_from_b;
            logic                  in_fire;
            logic                  out_fire;
            logic [DATA_WIDTH-1:0] a_dat_q;
            logic [DATA_WIDTH-1:0] a_dat_d;
            logic [DATA_WIDTH-1:0] b_dat_q;
            state_e                state;

            assign state    = decode_state(a_full_q, b_full_q);
            assign in_fire  = valid_i & ~b_full_q;
            assign out_fire = a_full_q & ready_i;

            always_comb begin
                a_full_d = a_full_q;
                b_full_d = b_full_q;
                a_load   = 1'b0;
                b_load   = 1'b0;
                a_from_b = 1'b0;
                if (flush_i) begin
                    // Flags clear; data registers keep stale contents.
                    a_full_d = 1'b0;
                    b_full_d = 1'b0;
                end else begin
                    unique case (state)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                a_load   = 1'b1;
                                a_full_d = 1'b1;
                            end
                        end
                        ST_ONE: begin
                            if (in_fire && out_fire) begin
                                a_load = 1'b1;
                            end else if (in_fire) begin
                                b_load   = 1'b1;
                                b_full_d = 1'b1;
                            end else if (out_fire) begin
                                a_full_d = 1'b0;
                            end
                        end
                        ST_FULL: begin
                            if (out_fire) begin
                                a_load   = 1'b1;
                                a_from_b = 1'b1;
                                b_full_d = 1'b0;
                            end
                        end
                        default: begin
                            a_full_d = 1'b0;
                            b_full_d = 1'b0;
                        end
                    endcase
                end
            end

            assign a_dat_d = a_from_b ? b_dat_q : dat_i;

            dfflr #(.DATA_WIDTH(1)) u_a_full (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .en_i    (1'b1),
                .d_i     (a_full_d),
                .q_o     (a_full_q)
            );

            dfflr #(.DATA_WIDTH(1)) u_b_full (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .en_i    (1'b1),
                .d_i     (b_full_d),
                .q_o     (b_full_q)
            );

            dfflr #(.DATA_WIDTH(DATA_WIDTH)) u_a_dat (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .en_i    (a_load),
                .d_i     (a_dat_d),
                .q_o     (a_dat_q)
            );

            dfflr #(.DATA_WIDTH(DATA_WIDTH)) u_b_dat (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .en_i    (b_load),
                .d_i     (dat_i),
                .q_o     (b_dat_q)
            );

            assign valid_o = a_full_q;
            assign dat_o   = a_dat_q;
            assign ready_o = ~b_full_q;
            assign count_o = {1'b0, a_full_q} + {1'b0, b_full_q};
        end
    endgenerate

endmodule

// File: tb/tb_spill_reg.sv
// Bench for spill_reg: occupancy-queue reference model checked every cycle,
// directed scenarios with literal expectations, random traffic and a BYPASS build.
module tb_spill_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] dat_in;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] dat_out;
    logic [1:0]  count;

    logic        b_valid_in;
    logic        b_ready_out;
    logic [7:0]  b_dat_in;
    logic        b_valid_out;
    logic        b_ready_in;
    logic [7:0]  b_dat_out;
    logic [1:0]  b_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] model_q[$];
    int unsigned emitted = 0;
    logic        hold_chk = 1'b0;
    logic [31:0] hold_dat = '0;

    always #5 clk = ~clk;

    spill_reg #(.DATA_WIDTH(32), .BYPASS(1'b0)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .dat_i   (dat_in),
        .valid_o (valid_out),
        .ready_i (ready_in),
        .dat_o   (dat_out),
        .count_o (count)
    );

    spill_reg #(.DATA_WIDTH(8), .BYPASS(1'b1)) dut_byp (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
        .valid_i (b_valid_in),
        .ready_o (b_ready_out),
        .dat_i   (b_dat_in),
        .valid_o (b_valid_out),
        .ready_i (b_ready_in),
        .dat_o   (b_dat_out),
        .count_o (b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the block is a FIFO of depth 2 whose head is what is shown.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            hold_chk = 1'b0;
        end else begin
            automatic bit m_valid = (model_q.size() > 0);
            automatic bit m_ready = (model_q.size() < 2);
            automatic bit inf     = valid_in & m_ready;
            automatic bit outf    = m_valid & ready_in;
            hold_chk = valid_out & ~ready_in & ~flush;
            hold_dat = dat_out;
            if (flush) begin
                model_q.delete();
            end else begin
                if (outf) begin
                    void'(model_q.pop_front());
                    emitted++;
                end
                if (inf) model_q.push_back(dat_in);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_o", valid_out, (model_q.size() > 0));
            chk("ready_o", ready_out, (model_q.size() < 2));
            chk("count_o", count, model_q.size());
            if (model_q.size() > 0) chk("dat_o", dat_out, model_q[0]);
            if (hold_chk) begin
                chk("hold_valid", valid_out, 1'b1);
                chk("hold_dat", dat_out, hold_dat);
            end
        end
    end

    initial begin
        logic [31:0] stream_exp [3];
        logic [31:0] bp_exp [3];
        stream_exp[0] = 32'h11; stream_exp[1] = 32'h22; stream_exp[2] = 32'h33;
        bp_exp[0] = 32'hA0; bp_exp[1] = 32'hA1; bp_exp[2] = 32'hA2;

        rst_n = 1'b0; flush = 1'b0; valid_in = 1'b1; dat_in = 32'h55; ready_in = 1'b0;
        b_valid_in = 1'b0; b_ready_in = 1'b0; b_dat_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid_o", valid_out, 1'b0);
        chk("rst_ready_o", ready_out, 1'b1);
        chk("rst_dat_o", dat_out, 32'h0);
        chk("rst_count_o", count, 2'd0);
        valid_in = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Streaming with ready_i held high.
        ready_in = 1'b1; valid_in = 1'b1; dat_in = 32'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stream_valid", valid_out, 1'b1);
            chk("stream_dat", dat_out, stream_exp[i]);
            chk("stream_count", count, 2'd1);
            chk("stream_ready", ready_out, 1'b1);
            if (i < 2) dat_in = stream_exp[i+1];
            else valid_in = 1'b0;
        end
        @(negedge clk);
        chk("stream_drain", count, 2'd0);

        // Backpressure until FULL, then release.
        ready_in = 1'b0; valid_in = 1'b1; dat_in = 32'hA0;
        @(negedge clk);
        dat_in = 32'hA1;
        @(negedge clk);
        chk("bp_count", count, 2'd2);
        chk("bp_ready", ready_out, 1'b0);
        dat_in = 32'hA2;
        @(negedge clk);
        chk("bp_hold_dat", dat_out, bp_exp[0]);
        chk("bp_hold_count", count, 2'd2);
        ready_in = 1'b1;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            chk("bp_drain_valid", valid_out, 1'b1);
            chk("bp_drain_dat", dat_out, bp_exp[i]);
            if (i == 1) chk("bp_ready_back", ready_out, 1'b1);
            else valid_in = 1'b0;
        end
        @(negedge clk);
        chk("bp_empty", count, 2'd0);

        // Flush while FULL, with ready_i high in the flush cycle.
        ready_in = 1'b0; valid_in = 1'b1; dat_in = 32'hB0;
        @(negedge clk);
        dat_in = 32'hB1;
        @(negedge clk);
        chk("fl_full", count, 2'd2);
        valid_in = 1'b0; flush = 1'b1; ready_in = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_valid", valid_out, 1'b0);
        chk("fl_count", count, 2'd0);
        chk("fl_ready", ready_out, 1'b1);
        @(negedge clk);
        chk("fl_still_empty", valid_out, 1'b0);

        // Random traffic with occasional flushes.
        for (int c = 0; c < 10000; c++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 2) != 0);
            dat_in   = $urandom;
            flush    = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        valid_in = 1'b0; flush = 1'b0; ready_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rand_drained", count, 2'd0);
        if (emitted < 1000) chk("rand_throughput", emitted, 32'd1000);

        // Async reset mid-transfer.
        ready_in = 1'b0; valid_in = 1'b1; dat_in = 32'hC0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_valid", valid_out, 1'b0);
        chk("mid_rst_count", count, 2'd0);
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // BYPASS build is combinational.
        for (int v = 0; v < 8; v++) begin
            b_valid_in = v[0];
            b_ready_in = v[1];
            b_dat_in   = 8'($urandom);
            #1;
            chk("byp_valid", b_valid_out, b_valid_in);
            chk("byp_ready", b_ready_out, b_ready_in);
            chk("byp_dat", b_dat_out, b_dat_in);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
